cp0_int_unit: RTL and testbench
===============================

Name: cp0_int_unit

Overview:
- Coprocessor-0 and interrupt-request block inside `mips`, at the M-stage "macro PC" point.
- Downstream consumer of the top-level `interrupt` line and other hardware interrupt sources.
- Samples the interrupt lines into Cause.IP and applies SR masking. Arbitrates interrupts against synchronous exceptions from the pipeline, saves EPC/BD/ExcCode, and drives a single-cycle flush/redirect request to the handler entry.
- Serves mfc0/mtc0/eret for the pipeline.

Parameters:
- EXC_ENTRY, 32'h0000_4180, handler PC driven on redirect.
- HW_INT_W, 6, number of hardware interrupt lines (Cause.IP / SR.IM width).
- PRID_VAL, 32'h2021_0707, read-only PRId contents.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- hw_int  in  HW_INT_W  level interrupt lines; bit 2 is the top-level `interrupt`.
- pc_valid  in  1  M stage holds a real instruction (not a bubble).
- macro_pc  in  32  PC of the M-stage instruction.
- bd_in  in  1  M-stage instruction is in a branch delay slot.
- exc_in  in  1  M-stage instruction carries a synchronous exception.
- exc_code_in  in  5  ExcCode for exc_in.
- cp0_we  in  1  mtc0 commit in M.
- cp0_addr  in  5  CP0 register number.
- cp0_wdata  in  32  mtc0 data.
- cp0_rdata  out  32  mfc0 data, combinational on cp0_addr.
- eret  in  1  eret in M.
- req  out  1  flush pipeline and redirect this cycle.
- handler_pc  out  32  redirect target when req=1.
- epc_out  out  32  current EPC, used by eret.

Behaviour:
- Registers and reset values (reset=0 clears asynchronously):
  - SR(12) = 0. IM = [15:10], EXL = [1], IE = [0]; other bits read 0.
  - Cause(13) = 0. BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - EPC(14) = 0.
  - PRId(15) = PRID_VAL.
- IP sampling: Cause.IP <= hw_int on every clock edge, independent of SR and EXL.
  - hw_int to req latency is exactly 1 cycle.
  - Deasserting hw_int clears IP one cycle later; there is no sticky latch.
- int_pend = SR.IE & ~SR.EXL & |(Cause.IP & SR.IM).
- req = pc_valid & (int_pend | (exc_in & ~SR.EXL)). Purely combinational on registered state plus M inputs.
- No entry on bubbles: a pending interrupt waits while pc_valid=0 and fires on the next valid cycle.
- Exception while EXL=1 is ignored: req stays 0.
- handler_pc = EXC_ENTRY whenever req=1, and 0 otherwise.
- On a clock edge with req=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? macro_pc-4 : macro_pc, with bits [1:0] forced to 0.
  - Cause.ExcCode <= int_pend ? 0 : exc_code_in. Interrupt has priority over a simultaneous exception.
- mtc0, only when req=0:
  - SR: writes IM, EXL and IE.
  - EPC: writes bits [31:2]; bits [1:0] are forced to 0.
  - Cause, PRId and other addresses: write ignored.
  - mtc0 in the same cycle as req: write dropped, exception updates win.
- eret with req=0: SR.EXL <= 0 on the next edge.
- eret with req=1: req wins and EXL stays 1.
- The redirect itself is the pipeline's job; this block only exposes epc_out.
- mfc0 reads:
  - Reads return the register value before this cycle's edge; there is no write-through bypass.
  - Unmapped addresses read 0.
- Reset mid-interrupt: state is cleared immediately. After release, IP resamples on the first edge.

Decomposition:
- Shared package cp0_pkg holds:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Bit-field positions: IM_LO=10, IM_HI=15, EXL=1, IE=0, BD=31, EXC_LO=2, EXC_HI=6.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- Sub-module cp0_int_arb is natural:
  - Purely combinational.
  - Computes int_pend, req and the selected ExcCode from IP/IM/IE/EXL/exc_in/pc_valid.
  - Allows arbitration to be unit-checked in isolation.

Test Plan:
- Interrupt entry:
  - Setup: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1).
  - Stimulus: hw_int=6'b000001 at edge t, with pc_valid=1 and macro_pc=32'h0000_3020.
  - Required: req=1 in cycle t+1 with handler_pc=32'h0000_4180. After that edge: EPC=32'h0000_3020, Cause=32'h0000_0400, SR reads 32'h0000_0403.
- Delay-slot exception:
  - Stimulus: exc_in=1, exc_code_in=12, bd_in=1, macro_pc=32'h0000_3024, EXL=0.
  - Required: req=1; EPC=32'h0000_3020; Cause=32'h8000_0030.
- Interrupt beats exception:
  - Stimulus: int_pend=1 and exc_in=1 with code 4 in the same cycle.
  - Required: ExcCode=0.
  - Follow-on: mtc0 EPC in that same cycle is dropped.
- Masking and bubbles:
  - Stimulus: IE=0 with hw_int=6'h3F held for 6 cycles.
  - Required: req stays 0 while IP reads 6'h3F.
  - Stimulus: set IE=1 while pc_valid=0 for 3 cycles.
  - Required: req=0 until the first pc_valid=1 cycle, then req=1.
- eret and nesting:
  - Stimulus: while EXL=1, an interrupt and exc_in arrive.
  - Required: req=0.
  - Stimulus: eret.
  - Required: EXL=0 next cycle, and req reasserts if hw_int is still high.
- Async reset:
  - Stimulus: drop reset mid-handler, off a clock edge.
  - Required: SR/Cause/EPC read 0 and PRId reads 32'h2021_0707 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 register numbers, bit-field positions and
//                ExcCode values for the interrupt/exception unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Bit-field positions inside SR / Cause
    localparam int IM_LO  = 10;
    localparam int IM_HI  = 15;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int EXC_LO = 2;
    localparam int EXC_HI = 6;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage
`default_nettype wire

// File: rtl/cp0_int_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_int_arb
//  Description : Combinational arbitration of masked hardware interrupts
//                against a synchronous exception from the M stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_int_arb
    import cp0_pkg::*;
#(
    parameter int HW_INT_W = 6
) (
    input  logic [HW_INT_W-1:0] ip,
    input  logic [HW_INT_W-1:0] im,
    input  logic                ie,
    input  logic                exl,
    input  logic                exc_in,
    input  logic [4:0]          exc_code_in,
    input  logic                pc_valid,
    output logic                int_pend,
    output logic                req,
    output logic [4:0]          exc_code
);

    // Interrupts outrank exceptions; nothing is taken on a bubble or while EXL is set.
    always_comb begin
        int_pend = ie & ~exl & (|(ip & im));
        req      = pc_valid & (int_pend | (exc_in & ~exl));
        exc_code = int_pend ? EXC_INT : exc_code_in;
    end

endmodule
`default_nettype wire

// File: rtl/cp0_int_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_int_unit
//  Description : Coprocessor-0 register file (SR/Cause/EPC/PRId) with
//                interrupt sampling, exception entry and eret handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_int_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter int          HW_INT_W  = 6,
    parameter logic [31:0] PRID_VAL  = 32'h2021_0707
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                pc_valid,
    input  logic [31:0]         macro_pc,
    input  logic                bd_in,
    input  logic                exc_in,
    input  logic [4:0]          exc_code_in,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         handler_pc,
    output logic [31:0]         epc_out
);

    logic [HW_INT_W-1:0] sr_im;
    logic                sr_exl;
    logic                sr_ie;
    logic                cause_bd;
    logic [HW_INT_W-1:0] cause_ip;
    logic [4:0]          cause_exc;
    logic [31:0]         epc;

    logic                int_pend;
    logic [4:0]          sel_code;
    logic [31:0]         epc_target;
    logic                sr_wr;
    logic                epc_wr;
    logic [31:0]         sr_word;
    logic [31:0]         cause_word;

    cp0_int_arb #(
        .HW_INT_W (HW_INT_W)
    ) u_arb (
        .ip          (cause_ip),
        .im          (sr_im),
        .ie          (sr_ie),
        .exl         (sr_exl),
        .exc_in      (exc_in),
        .exc_code_in (exc_code_in),
        .pc_valid    (pc_valid),
        .int_pend    (int_pend),
        .req         (req),
        .exc_code    (sel_code)
    );

    // Entry PC (delay-slot aware, word aligned) and mtc0 write strobes, which lose to req.
    always_comb begin
        epc_target = (bd_in ? (macro_pc - 32'd4) : macro_pc) & 32'hFFFF_FFFC;
        sr_wr      = ~req & cp0_we & (cp0_addr == CP0_SR);
        epc_wr     = ~req & cp0_we & (cp0_addr == CP0_EPC);
        handler_pc = req ? EXC_ENTRY : 32'h0000_0000;
        epc_out    = epc;
    end

    // CP0 state: IP free-runs from hw_int; exception entry outranks mtc0 and eret.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= sel_code;
                epc       <= epc_target;
            end else begin
                if (sr_wr) begin
                    sr_im  <= cp0_wdata[IM_LO +: HW_INT_W];
                    sr_exl <= cp0_wdata[EXL];
                    sr_ie  <= cp0_wdata[IE];
                end
                if (epc_wr) begin
                    epc <= cp0_wdata & 32'hFFFF_FFFC;
                end
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux on current register contents; unmapped numbers read zero.
    always_comb begin
        sr_word                     = '0;
        sr_word[IM_LO +: HW_INT_W]  = sr_im;
        sr_word[EXL]                = sr_exl;
        sr_word[IE]                 = sr_ie;
        cause_word                  = '0;
        cause_word[BD]              = cause_bd;
        cause_word[IM_LO +: HW_INT_W] = cause_ip;
        cause_word[EXC_HI:EXC_LO]   = cause_exc;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_word;
            CP0_CAUSE: cp0_rdata = cause_word;
            CP0_EPC:   cp0_rdata = epc;
            CP0_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_int_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_int_unit
//  Description : Directed self-checking bench for cp0_int_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_int_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic        pc_valid;
    logic [31:0] macro_pc;
    logic        bd_in;
    logic        exc_in;
    logic [4:0]  exc_code_in;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    cp0_int_unit dut (
        .clk         (clk),
        .reset       (reset),
        .hw_int      (hw_int),
        .pc_valid    (pc_valid),
        .macro_pc    (macro_pc),
        .bd_in       (bd_in),
        .exc_in      (exc_in),
        .exc_code_in (exc_code_in),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .eret        (eret),
        .req         (req),
        .handler_pc  (handler_pc),
        .epc_out     (epc_out)
    );

    // 20-unit clock, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        step();
        cp0_we    = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b0; hw_int = '0; pc_valid = 1'b0; macro_pc = '0; bd_in = 1'b0;
        exc_in = 1'b0; exc_code_in = '0; cp0_we = 1'b0; cp0_addr = '0;
        cp0_wdata = '0; eret = 1'b0;

        // Reset values
        #3;
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd15, "rst_prid", 32'h2021_0707);
        check("rst_req", {31'b0, req}, 32'h0);
        #2 reset = 1'b1;
        step();

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "sr_write", 32'h0000_0401);
        hw_int = 6'b000001; pc_valid = 1'b1; macro_pc = 32'h0000_3020;
        #1 check("int_latency_pre", {31'b0, req}, 32'h0);
        step();
        check("int_req", {31'b0, req}, 32'h1);
        check("int_handler_pc", handler_pc, 32'h0000_4180);
        step();
        rd(5'd14, "int_epc", 32'h0000_3020);
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr", 32'h0000_0403);
        check("int_no_retrigger", {31'b0, req}, 32'h0);

        // Nesting blocked while EXL=1, eret re-enables
        exc_in = 1'b1; exc_code_in = 5'd12;
        #1 check("nest_req", {31'b0, req}, 32'h0);
        check("nest_hpc", handler_pc, 32'h0);
        step();
        check("nest_req2", {31'b0, req}, 32'h0);
        exc_in = 1'b0;
        do_eret();
        rd(5'd12, "eret_sr", 32'h0000_0401);
        check("eret_rereq", {31'b0, req}, 32'h1);
        hw_int = 6'b0;
        step();
        rd(5'd12, "reentry_sr", 32'h0000_0403);
        do_eret();
        rd(5'd12, "eret2_sr", 32'h0000_0401);
        check("eret2_req", {31'b0, req}, 32'h0);

        // Delay-slot exception
        exc_in = 1'b1; exc_code_in = 5'd12; bd_in = 1'b1; macro_pc = 32'h0000_3024;
        #1 check("ds_req", {31'b0, req}, 32'h1);
        step();
        exc_in = 1'b0; bd_in = 1'b0;
        rd(5'd14, "ds_epc", 32'h0000_3020);
        rd(5'd13, "ds_cause", 32'h8000_0030);
        rd(5'd12, "ds_sr", 32'h0000_0403);
        do_eret();
        rd(5'd12, "ds_eret_sr", 32'h0000_0401);

        // Cause is read-only to mtc0; unmapped reads zero
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_ro", 32'h8000_0030);
        rd(5'd3, "unmapped", 32'h0);

        // Interrupt beats exception; simultaneous mtc0 EPC dropped
        hw_int = 6'b000001; macro_pc = 32'h0000_3040;
        step();
        exc_in = 1'b1; exc_code_in = 5'd4;
        cp0_we = 1'b1; cp0_wdata = 32'h1234_5678;
        rd(5'd14, "prio_no_bypass", 32'h0000_3020);
        check("prio_req", {31'b0, req}, 32'h1);
        step();
        cp0_we = 1'b0; exc_in = 1'b0; hw_int = 6'b0;
        rd(5'd13, "prio_cause", 32'h0000_0400);
        rd(5'd14, "prio_epc", 32'h0000_3040);
        do_eret();

        // mtc0 EPC when no request
        mtc0(5'd14, 32'h1234_5677);
        rd(5'd14, "epc_write", 32'h1234_5674);
        check("epc_out", epc_out, 32'h1234_5674);

        // Masking with IE=0
        mtc0(5'd12, 32'h0000_FC00);
        hw_int = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mask_req", {31'b0, req}, 32'h0);
        end
        rd(5'd13, "mask_ip", 32'h0000_FC00);

        // Pending interrupt waits through bubbles
        pc_valid = 1'b0;
        mtc0(5'd12, 32'h0000_FC01);
        for (int i = 0; i < 3; i++) begin
            check("bubble_req", {31'b0, req}, 32'h0);
            step();
        end
        pc_valid = 1'b1; macro_pc = 32'h0000_3050;
        #1 check("bubble_fire", {31'b0, req}, 32'h1);
        step();
        rd(5'd14, "handler_epc", 32'h0000_3050);

        // Asynchronous reset mid-handler, off the clock edge
        #2 reset = 1'b0;
        rd(5'd12, "arst_sr", 32'h0);
        rd(5'd13, "arst_cause", 32'h0);
        rd(5'd14, "arst_epc", 32'h0);
        rd(5'd15, "arst_prid", 32'h2021_0707);
        check("arst_req", {31'b0, req}, 32'h0);
        #3 reset = 1'b1;
        step();
        rd(5'd13, "post_rst_ip", 32'h0000_FC00);
        rd(5'd12, "post_rst_sr", 32'h0);
        check("post_rst_req", {31'b0, req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
